// File: rtl/bottle_pkg.sv
// Shared types for the bottling-line fill sequencer: FSM state codes, BCD digit
// and two-digit BCD count types, and the BCD increment helper.
package bottle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_SWAP  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hi;
        bcd_digit_t lo;
    } bcd2_t;

    localparam int unsigned SWAP_CYCLES_DEFAULT = 8;

    // Digits above 9 are treated as 9 so a corrupted count falls back into BCD range.
    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.lo >= 4'd9) begin
            r.lo = 4'd0;
            r.hi = (v.hi >= 4'd9) ? 4'd0 : v.hi + 4'd1;
        end else begin
            r.lo = v.lo + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bottle_seq_bcd2_counter.sv
// Two-digit BCD counter with synchronous clear and increment; also exposes the
// value it would take on increment so the sequencer can compare against targets early.
module bcd2_counter
    import bottle_pkg::*;
(
    input  logic  clk,
    input  logic  srst,
    input  logic  clr_i,
    input  logic  inc_i,
    output bcd2_t cnt_o,
    output bcd2_t nxt_o
);

    bcd2_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = bcd2_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nxt_o = bcd2_inc(cnt_q);

endmodule

// File: rtl/bottle_seq.sv
// Bottling-line fill sequencer: pill/bottle targets, valve and conveyor swap control.
// Build option BOTTLE_AUTO_ADVANCE_EN: SWAP returns straight to FILL/PAUSE instead of HOLD.
module bottle_seq
    import bottle_pkg::*;
#(
    parameter int unsigned SWAP_CYCLES = SWAP_CYCLES_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN_set,
    input  logic       EN_work,
    input  logic       isWork,
    input  logic       conti,
    input  logic       set_pill,
    input  logic       set_bot,
    input  logic [3:0] Cinl,
    input  logic [3:0] Cinh,
    input  logic       pill,
    output logic [3:0] nowL,
    output logic [3:0] nowH,
    output logic [3:0] seqL,
    output logic [3:0] seqH,
    output logic       valve,
    output logic       swap,
    output logic       allFull,
    output logic       err,
    output logic [2:0] state
);

    localparam logic [7:0] SWAP_LOAD = 8'(SWAP_CYCLES);

    state_e     state_q, state_d;
    bcd2_t      pill_tgt_q, pill_tgt_d;
    bcd2_t      bot_tgt_q, bot_tgt_d;
    logic       err_q, err_d;
    logic [7:0] tmr_q, tmr_d;
    logic       conti_q;
    logic       valve_q, swap_q, full_q;

    bcd2_t now_cnt, now_nxt, seq_cnt, seq_nxt;
    logic  now_clr, now_inc, seq_clr, seq_inc;
    logic  load_ok, conti_rise;
    state_e resume_st;

    assign load_ok    = (Cinl <= 4'd9) && (Cinh <= 4'd9);
    assign conti_rise = conti && !conti_q;
    assign resume_st  = isWork ? ST_FILL : ST_PAUSE;

    always_comb begin
        state_d    = state_q;
        pill_tgt_d = pill_tgt_q;
        bot_tgt_d  = bot_tgt_q;
        err_d      = err_q;
        tmr_d      = tmr_q;
        now_clr    = 1'b0;
        now_inc    = 1'b0;
        seq_clr    = 1'b0;
        seq_inc    = 1'b0;

        if (EN_set) begin
            state_d = ST_IDLE;
            now_clr = 1'b1;
            seq_clr = 1'b1;
            if (set_pill || set_bot) begin
                if (load_ok) begin
                    err_d = 1'b0;
                    if (set_pill) pill_tgt_d = '{hi: Cinh, lo: Cinl};
                    if (set_bot)  bot_tgt_d  = '{hi: Cinh, lo: Cinl};
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (EN_work && isWork) begin
                        if (pill_tgt_q != '0 && bot_tgt_q != '0) state_d = ST_FILL;
                        else                                     err_d   = 1'b1;
                    end
                end
                ST_FILL: begin
                    if (!EN_work) begin
                        state_d = ST_IDLE;
                    end else begin
                        now_inc = pill;
                        // Reaching the target outranks a simultaneous pause request.
                        if (pill && now_nxt == pill_tgt_q) begin
                            state_d = ST_SWAP;
                            tmr_d   = SWAP_LOAD;
                        end else if (!isWork) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!EN_work)    state_d = ST_IDLE;
                    else if (isWork) state_d = ST_FILL;
                end
                ST_SWAP: begin
                    if (!EN_work) begin
                        state_d = ST_IDLE;
                    end else if (tmr_q <= 8'd1) begin
                        now_clr = 1'b1;
                        seq_inc = 1'b1;
                        if (seq_nxt == bot_tgt_q) begin
                            state_d = ST_DONE;
                        end else begin
`ifdef BOTTLE_AUTO_ADVANCE_EN
                            state_d = resume_st;
`else
                            state_d = ST_HOLD;
`endif
                        end
                    end else begin
                        tmr_d = tmr_q - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (!EN_work)        state_d = ST_IDLE;
                    else if (conti_rise) state_d = resume_st;
                end
                ST_DONE: begin
                    if (conti_rise) begin
                        seq_clr = 1'b1;
                        state_d = resume_st;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pill_tgt_q <= '0;
            bot_tgt_q  <= '0;
            err_q      <= 1'b0;
            tmr_q      <= 8'd0;
            conti_q    <= 1'b0;
            valve_q    <= 1'b0;
            swap_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pill_tgt_q <= pill_tgt_d;
            bot_tgt_q  <= bot_tgt_d;
            err_q      <= err_d;
            tmr_q      <= tmr_d;
            conti_q    <= conti;
            // Decoded from the next state so they switch on the same edge as the state.
            valve_q    <= (state_d == ST_FILL);
            swap_q     <= (state_d == ST_SWAP);
            full_q     <= (state_d == ST_DONE);
        end
    end

    bcd2_counter u_now (
        .clk   (CLK),
        .srst  (RST),
        .clr_i (now_clr),
        .inc_i (now_inc),
        .cnt_o (now_cnt),
        .nxt_o (now_nxt)
    );

    bcd2_counter u_seq (
        .clk   (CLK),
        .srst  (RST),
        .clr_i (seq_clr),
        .inc_i (seq_inc),
        .cnt_o (seq_cnt),
        .nxt_o (seq_nxt)
    );

    assign nowL    = now_cnt.lo;
    assign nowH    = now_cnt.hi;
    assign seqL    = seq_cnt.lo;
    assign seqH    = seq_cnt.hi;
    assign valve   = valve_q;
    assign swap    = swap_q;
    assign allFull = full_q;
    assign err     = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_bottle_seq.sv
// Self-checking bench for bottle_seq: directed scenarios plus randomized stimulus,
// every cycle compared against a decimal-integer behavioural model of the sequencer.
module tb_bottle_seq;

    localparam int SWP = 8;

    logic       CLK = 1'b0;
    logic       RST, EN_set, EN_work, isWork, conti, set_pill, set_bot, pill;
    logic [3:0] Cinl, Cinh;
    logic [3:0] nowL, nowH, seqL, seqH;
    logic       valve, swap, allFull, err;
    logic [2:0] state;

    bottle_seq #(.SWAP_CYCLES(SWP)) dut (
        .CLK(CLK), .RST(RST), .EN_set(EN_set), .EN_work(EN_work), .isWork(isWork),
        .conti(conti), .set_pill(set_pill), .set_bot(set_bot), .Cinl(Cinl), .Cinh(Cinh),
        .pill(pill), .nowL(nowL), .nowH(nowH), .seqL(seqL), .seqH(seqH), .valve(valve),
        .swap(swap), .allFull(allFull), .err(err), .state(state)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int swap_hi_cnt = 0;

    // Model: modes 0 idle, 1 fill, 2 pause, 3 swap, 4 hold, 5 done; counts as plain integers.
    int m_mode = 0, m_now = 0, m_seq = 0, m_ptgt = 0, m_btgt = 0, m_age = 0;
    bit m_err = 0, m_cprev = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int resume_mode();
        return isWork ? 1 : 2;
    endfunction

    task automatic model_step();
        bit rise;
        rise = conti && !m_cprev;
        if (RST) begin
            m_mode = 0; m_now = 0; m_seq = 0; m_ptgt = 0; m_btgt = 0; m_err = 0; m_cprev = 0;
            return;
        end
        m_cprev = conti;
        if (EN_set) begin
            m_mode = 0; m_now = 0; m_seq = 0;
            if (set_pill || set_bot) begin
                if (Cinl <= 9 && Cinh <= 9) begin
                    m_err = 0;
                    if (set_pill) m_ptgt = Cinh * 10 + Cinl;
                    if (set_bot)  m_btgt = Cinh * 10 + Cinl;
                end else begin
                    m_err = 1;
                end
            end
            return;
        end
        case (m_mode)
            0: if (EN_work && isWork) begin
                   if (m_ptgt != 0 && m_btgt != 0) m_mode = 1;
                   else m_err = 1;
               end
            1: if (!EN_work) m_mode = 0;
               else begin
                   if (pill) m_now = (m_now + 1) % 100;
                   if (pill && m_now == m_ptgt) begin m_mode = 3; m_age = 0; end
                   else if (!isWork) m_mode = 2;
               end
            2: if (!EN_work) m_mode = 0; else if (isWork) m_mode = 1;
            3: if (!EN_work) m_mode = 0;
               else begin
                   m_age++;
                   if (m_age == SWP) begin
                       m_now = 0;
                       m_seq = (m_seq + 1) % 100;
                       if (m_seq == m_btgt) m_mode = 5;
                       else begin
`ifdef BOTTLE_AUTO_ADVANCE_EN
                           m_mode = resume_mode();
`else
                           m_mode = 4;
`endif
                       end
                   end
               end
            4: if (!EN_work) m_mode = 0; else if (rise) m_mode = resume_mode();
            5: if (rise) begin m_seq = 0; m_mode = resume_mode(); end
            default: m_mode = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("state", int'(state), m_mode);
        chk("now", int'({nowH, nowL}), to_bcd(m_now));
        chk("seq", int'({seqH, seqL}), to_bcd(m_seq));
        chk("valve", int'(valve), int'(m_mode == 1));
        chk("swap", int'(swap), int'(m_mode == 3));
        chk("allFull", int'(allFull), int'(m_mode == 5));
        chk("err", int'(err), int'(m_err));
        swap_hi_cnt += int'(swap);
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        RST = 1; EN_set = 0; EN_work = 0; isWork = 0; conti = 0;
        set_pill = 0; set_bot = 0; pill = 0; Cinl = 0; Cinh = 0;
        cycle(); cycle();
        RST = 0;
    endtask

    task automatic do_load(input bit sp, input bit sb, input int h, input int l);
        EN_set = 1; set_pill = sp; set_bot = sb; Cinh = 4'(h); Cinl = 4'(l);
        cycle();
        set_pill = 0; set_bot = 0; EN_set = 0;
    endtask

    task automatic wait_mode(input int m, input int budget);
        int n = 0;
        while (m_mode != m && n < budget) begin
            if (m_mode == 4) begin conti = 1; cycle(); conti = 0; end
            else cycle();
            n++;
        end
        if (m_mode != m) chk("timeout_wait_mode", m_mode, m);
    endtask

    task automatic send_pills(input int n);
        for (int i = 0; i < n; i++) begin
            wait_mode(1, 40);
            pill = 1;
            cycle();
            pill = 0;
        end
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_state", int'(state), 0);
        chk("rst_outs", int'({nowH, nowL, seqH, seqL, valve, swap, allFull, err}), 0);

        // Batch of two bottles, three pills each
        do_load(1, 0, 0, 3);
        do_load(0, 1, 0, 2);
        EN_work = 1; isWork = 1;
        cycle();
        chk("start_valve", int'(valve), 1);
        swap_hi_cnt = 0;
        send_pills(6);
        wait_mode(5, 40);
        chk("batch_state", int'(state), 5);
        chk("batch_seq", int'({seqH, seqL}), 'h02);
        chk("batch_full", int'(allFull), 1);
        chk("batch_swap_cycles", swap_hi_cnt, 2 * SWP);

        // Tens carry with pill target 12
        do_load(1, 1, 1, 2);
        cycle();
        send_pills(9);
        chk("now_09", int'({nowH, nowL}), 'h09);
        send_pills(1);
        chk("now_10", int'({nowH, nowL}), 'h10);
        chk("no_early_swap", int'(swap), 0);
        send_pills(2);
        chk("swap_at_12", int'(swap), 1);
        chk("valve_off_at_12", int'(valve), 0);

        // Pause ignores pills
        do_load(1, 0, 0, 5);
        cycle();
        send_pills(2);
        isWork = 0;
        cycle();
        chk("pause_state", int'(state), 2);
        for (int i = 0; i < 3; i++) begin pill = 1; cycle(); pill = 0; cycle(); end
        isWork = 1;
        cycle();
        chk("pause_now", int'({nowH, nowL}), 'h02);
        chk("resume_state", int'(state), 1);

        // Rejected load keeps the old target
        do_load(1, 0, 0, 4);
        do_load(1, 0, 0, 10);
        chk("bad_load_err", int'(err), 1);
        cycle();
        send_pills(4);
        chk("old_target_swap", int'(swap), 1);
        do_reset();
        EN_work = 1; isWork = 1;
        cycle();
        chk("zero_tgt_state", int'(state), 0);
        chk("zero_tgt_err", int'(err), 1);

        // Exit of the first bottle's swap window
        do_load(1, 0, 0, 1);
        do_load(0, 1, 0, 3);
        cycle();
        send_pills(1);
        repeat (SWP) cycle();
`ifdef BOTTLE_AUTO_ADVANCE_EN
        chk("auto_fill", int'(state), 1);
`else
        chk("hold_state", int'(state), 4);
        chk("hold_valve", int'(valve), 0);
        cycle();
        chk("hold_stays", int'(state), 4);
        conti = 1;
        cycle();
        conti = 0;
        chk("hold_to_fill", int'(state), 1);
`endif

        // Reset in the middle of a swap window
        do_load(1, 1, 0, 2);
        cycle();
        send_pills(2);
        repeat (3) cycle();
        RST = 1;
        cycle();
        RST = 0;
        chk("rst_swap_state", int'(state), 0);
        chk("rst_swap_outs", int'({nowH, nowL, seqH, seqL, valve, swap, allFull, err}), 0);
        EN_work = 1; isWork = 1;
        cycle();
        chk("rst_targets_zero", int'(err), 1);

        // Randomized operation
        for (int r = 0; r < 15; r++) begin
            if (r % 5 == 4) do_reset();
            EN_set = 1;
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                set_pill = 1'($urandom % 2);
                set_bot  = 1'($urandom % 2);
                Cinh = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'd0;
                Cinl = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 5));
                cycle();
            end
            EN_set = 0; set_pill = 0; set_bot = 0;
            for (int c = 0; c < 200; c++) begin
                EN_work  = ($urandom % 40) != 0;
                isWork   = ($urandom % 10) != 0;
                pill     = 1'($urandom % 2);
                conti    = ($urandom % 4) == 0;
                EN_set   = ($urandom % 200) == 0;
                set_pill = ($urandom % 16) == 0;
                set_bot  = ($urandom % 16) == 0;
                Cinl     = 4'($urandom_range(0, 15));
                Cinh     = 4'($urandom_range(0, 1));
                RST      = ($urandom % 500) == 0;
                cycle();
            end
            RST = 0; EN_set = 0; set_pill = 0; set_bot = 0; pill = 0; conti = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
